// File: rtl/toggle_hs_pkg.sv
// Shared types and defaults for the toggle handshake receiver and its synchroniser.
package toggle_hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hs_state_e;

  localparam int   DATA_W_DEF      = 8;
  localparam int   SYNC_STAGES_DEF = 2;
  localparam logic TGL_RST_LVL     = 1'b0;

endpackage

// File: rtl/tgl_sync_edge.sv
// Toggle synchroniser: SYNC_STAGES flop chain plus a previous-level flop for edge detection.
// Usable on either side of a two-phase handshake (req or ack return path).
module tgl_sync_edge
  import toggle_hs_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tgl,
  output logic o_tgl_s,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{TGL_RST_LVL}};
      r_prev <= TGL_RST_LVL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_tgl};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_tgl_s = r_sync[SYNC_STAGES-1];
  assign o_edge  = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/toggle_hs_receiver.sv
// Receiving end of a two-phase req/ack handshake, presenting words on valid/ready.
// Optional sticky protocol-violation flag built only when TOGGLE_HS_PROTO_ERR_EN is defined.
module toggle_hs_receiver
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_tgl,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_ack_tgl,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_proto_err
);

  logic              w_req_edge;
  logic              w_unused_req_s;
  hs_state_e         r_state;
  logic              r_ack;
  logic              r_valid;
  logic              r_busy;
  logic [DATA_W-1:0] r_data;

  tgl_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_tgl  (i_req_tgl),
    .o_tgl_s(w_unused_req_s),
    .o_edge (w_req_edge)
  );

  // data_out only changes on the IDLE->HOLD capture; an edge seen in HOLD is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ack   <= TGL_RST_LVL;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_edge) begin
            r_data  <= i_data_in;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= ~r_ack;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef TOGGLE_HS_PROTO_ERR_EN
  logic r_proto_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_proto_err <= 1'b0;
    end else if ((r_state == HOLD) && w_req_edge) begin
      r_proto_err <= 1'b1;
    end
  end

  assign o_proto_err = r_proto_err;
`else
  assign o_proto_err = 1'b0;
`endif

  assign o_ack_tgl  = r_ack;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;
  assign o_data_out = r_data;

endmodule

// File: doc/toggle_hs_receiver.md
Name: toggle_hs_receiver

Overview:
- Receiving end of a two-phase (toggle) request/acknowledge handshake.
- The sender flips `req_tgl` once per transfer and holds `data_in` stable until it sees `ack_tgl` flip.
- This block synchronises `req_tgl`, captures `data_in` and presents it on a valid/ready interface.
- It flips `ack_tgl` once the local consumer accepts the word.

Parameters:
- DATA_W, 8, width of the transferred data word.
- SYNC_STAGES, 2, number of flops in the `req_tgl` synchroniser (legal range 2..4).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_tgl  in  1  request toggle from sender; may be asynchronous to clk.
- data_in  in  DATA_W  sender data; stable from the `req_tgl` flip until the `ack_tgl` flip.
- ack_tgl  out  1  acknowledge toggle back to sender.
- data_out  out  DATA_W  captured word.
- valid  out  1  data_out holds an unconsumed word.
- ready  in  1  consumer accepts data_out this cycle.
- busy  out  1  high in any state other than IDLE.
- proto_err  out  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): all outputs, sync flops, prev-level flop and state return to their reset values.
  - ack_tgl=0, valid=0, data_out=0, busy=0, proto_err=0.
  - Sync flops=0, prev-level flop=0, state=IDLE.
  - Effective immediately; an in-flight transfer is dropped and no ack is sent.
  - Sender is reset in the same domain event, so both toggle levels restart at 0.
- Synchroniser: `req_tgl` passes through a SYNC_STAGES flop chain to give `req_s`.
  - `req_edge` = `req_s` XOR `req_prev`.
  - `req_prev` loads `req_s` every cycle.
- FSM states:
  - IDLE:
    - On `req_edge`: data_out <= data_in, valid <= 1, go to HOLD.
    - Otherwise stay.
  - HOLD:
    - valid=1.
    - On valid&&ready: valid <= 0, ack_tgl <= ~ack_tgl, go to IDLE.
    - Otherwise hold data_out unchanged.
- Latency: a `req_tgl` flip sampled at edge 0 gives valid=1 after edge SYNC_STAGES+1. This is 3 edges at default.
- Ready may already be high when valid rises. The handshake then completes on the next edge: ack_tgl flips, and valid is low for the following cycle.
- Minimum spacing: at least one IDLE cycle occurs between consecutive words. A `req_edge` seen in that IDLE cycle is captured normally.
- Ready while valid=0 is ignored.
- data_out is not modified outside the IDLE->HOLD capture.
- A `req_edge` arriving while in HOLD is a sender violation. The edge is consumed: `req_prev` updates, and no second capture is made.

Optional Feature:
- Macro TOGGLE_HS_PROTO_ERR_EN.
- Defined:
  - proto_err is set on any `req_edge` while state=HOLD.
  - It stays set until rst_n is asserted.
  - busy and transfer behaviour are unchanged.
- Undefined: proto_err is tied to 0 and no detection logic is built.

Decomposition:
- Package `toggle_hs_pkg` holds:
  - the state enum (IDLE, HOLD);
  - DATA_W_DEF=8 and SYNC_STAGES_DEF=2 constants;
  - the `req_tgl`/`ack_tgl` reset level constant (0).
- One sub-module `tgl_sync_edge`:
  - parameterised SYNC_STAGES flop chain plus prev-level flop;
  - outputs `req_s` and `req_edge`;
  - async active-low reset.
  - Reusable for the sender side's `ack_tgl` return path.

Test Plan:
- Reset with rst_n=0 mid-HOLD, valid=1 -> valid, ack_tgl, data_out and busy go to 0 immediately without waiting for a clk edge; after release, state is IDLE.
- Single transfer with SYNC_STAGES=2, ready=1:
  - Drive data_in=8'hA5 and flip req_tgl 0->1.
  - valid rises after 3 edges with data_out=8'hA5.
  - ack_tgl flips 0->1 on the next edge, then valid=0.
- Consumer stall: ready=0 for 5 cycles after valid.
  - valid and data_out=8'h3C hold steady and ack_tgl does not change.
  - ready=1 -> ack_tgl flips within 1 edge.
- Back-to-back: sender flips req_tgl with data_in=8'h01, 8'h02, 8'h03, each time only after seeing the ack flip.
  - The consumer sees 01, 02, 03 in order.
  - ack_tgl ends at 1 (three flips).
- Violation: flip req_tgl again while in HOLD with data_in=8'hFF, then set ready=1.
  - data_out stays at the first word and only one ack flip occurs.
  - With TOGGLE_HS_PROTO_ERR_EN defined, proto_err=1 and stays set until reset.
  - With the macro undefined, proto_err=0.
- Width sweep: DATA_W=16 and SYNC_STAGES=3, data_in=16'hBEEF -> valid after 4 edges, data_out=16'hBEEF.
